// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small byte FIFO behind a valid/ready handshake.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQUENCY = 12000000,
  parameter int unsigned UART_BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       parity_error
);

  localparam int unsigned Cpb  = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int unsigned Half = Cpb / 2;
  localparam int unsigned CntW = (Cpb > 2) ? $clog2(Cpb) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PtrW + 1;
  localparam logic [CntW-1:0] BitLoad  = CntW'(Cpb - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(Half - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            sync1_q, rx_s;
  logic            frame_error_q;
  logic            par_bad;
  logic            push, pop, full, push_ok;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overrun_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s    <= sync1_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic parity_error_q;
  assign par_bad      = ^{shift_q, par_q};
  assign parity_error = parity_error_q;
`else
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q          <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= HalfLoad;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            // A high line at mid start bit is a glitch, silently dropped.
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              state_q <= StData;
              cnt_q   <= BitLoad;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            shift_q[idx_q] <= rx_s;
            cnt_q          <= BitLoad;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == '0) begin
            par_q   <= rx_s;
            cnt_q   <= BitLoad;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        StStop: begin
          if (cnt_q == '0) begin
            if (!rx_s) begin
              frame_error_q <= 1'b1;
              state_q       <= StBreak;
            end else begin
`ifdef UART_RX_PARITY_EN
              parity_error_q <= par_bad;
`endif
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StBreak: begin
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign frame_error = frame_error_q;

  // The push happens on the stop-sample edge itself so rx_valid rises the cycle after.
  assign push     = (state_q == StStop) && (cnt_q == '0) && rx_s && !par_bad;
  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign push_ok  = push && (!full || pop);
  assign rx_data  = mem_q[rd_ptr_q];
  assign overrun  = overrun_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Standalone UART receiver with a small output FIFO: the receive-side counterpart of the SoC's `uart_tx` line, for board-level tops that take serial input from the host (USB-UART bridge) into fabric logic. It synchronizes the asynchronous `uart_rx` pin, detects and validates start bits, samples 8N1 frames LSB first at mid-bit, and buffers received bytes behind a valid/ready handshake. Framing and overrun errors are reported as single-cycle pulses.

## Interface
- `CLOCK_FREQUENCY`, 12000000: clock frequency in Hz.
- `UART_BAUD_RATE`, 9600: line baud rate.
- `FIFO_DEPTH`, 4: byte FIFO entries. Must be a power of two and ≥ 2.

- `clock`  input  1  system clock. All logic is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `uart_rx`  input  1  serial line. Asynchronous to `clock`. Idle high.
- `rx_data`  output  8  byte at the FIFO head. Valid only while `rx_valid` is high.
- `rx_valid`  output  1  FIFO non-empty.
- `rx_ready`  input  1  consumer accepts the head byte.
- `frame_error`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- `parity_error`  output  1  one-cycle pulse on bad parity. Constant 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- Bit period constants:
  - CPB = CLOCK_FREQUENCY / UART_BAUD_RATE, integer division.
  - HALF = CPB / 2.
  - The cycle counter is wide enough for CPB−1.
- Input synchronizer: 2-flop, both stages reset to 1. The FSM sees only the second stage, `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP, BREAK.
- IDLE: when `rx_s`=0, go to START and load counter = HALF−1.
- START: when the counter reaches 0, sample `rx_s`.
  - If 1: glitch. Return to IDLE; nothing is reported.
  - If 0: go to DATA with counter = CPB−1 and bit index = 0.
- DATA: each time the counter reaches 0, shift `rx_s` into bit [index] (LSB first) and reload CPB−1.
  - After bit 7, go to STOP, or to PARITY when the macro is enabled.
- STOP: sample when the counter reaches 0.
  - 1: push the byte (see FIFO rules), then go to IDLE.
  - 0: pulse `frame_error`, discard the byte, go to BREAK.
- BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- FIFO rules:
  - `rx_valid` = count ≠ 0. `rx_data` = mem[rd_ptr].
  - Pop when `rx_valid && rx_ready`.
  - Push when full and no pop in the same cycle: byte dropped, `overrun` pulses, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: the push lands, and the pop is ignored because `rx_valid` was 0.
  - Pointers wrap modulo FIFO_DEPTH. The count saturates in the range 0..FIFO_DEPTH.
  - `rx_data` holds its value while `rx_valid`=1 and `rx_ready`=0.

## Timing
- Reset values:
  - FSM = IDLE; counters, pointers and count = 0; sync flops = 1.
  - `rx_data`=0, `rx_valid`=0, `frame_error`=0, `overrun`=0, `parity_error`=0.
- Reset asserted mid-frame aborts the frame. The partial byte is lost and the FIFO is emptied.
- Pin-to-detect latency: 2 cycles (synchronizer) + 1 cycle (IDLE→START).
- Start-bit check occurs HALF cycles after detection. Each later sample is CPB cycles after the previous one.
- `rx_valid` rises on the cycle after the stop-bit sample cycle when the FIFO was empty.
- Error pulses are registered: each is high for exactly the one cycle after its sample cycle.
- A new start bit is accepted on the cycle after the STOP sample, giving half a bit of tolerance for back-to-back frames.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1.
  - PARITY state samples a 9th bit CPB after bit 7.
  - If XOR(data, parity bit) ≠ 0, `parity_error` pulses together with the STOP sample and the byte is discarded.
  - The stop bit is still checked. A frame error takes priority: only `frame_error` pulses.
- `UART_RX_PARITY_EN` undefined: frame is 8N1, PARITY state is absent, `parity_error` is tied to 0.

## Test plan
All scenarios use CLOCK_FREQUENCY=1000000 and UART_BAUD_RATE=100000 (CPB=10, HALF=5), with FIFO_DEPTH=4 unless stated.
- Drive 0x55 as 8N1, `rx_ready`=1 → `rx_valid` pulses for one cycle with `rx_data`=0x55. No error pulses.
- Hold `rx_ready`=0 and send 0x01, 0x02, 0x03, 0x04, 0xA5 → four bytes retained in order, `overrun` pulses once after 0xA5's stop bit. Then assert `rx_ready` → 0x01..0x04 drain in order, then `rx_valid`=0.
- 3-cycle low glitch on an idle line → no state beyond START, no byte, no pulses.
- Send 0xC3 with the stop bit driven low, then hold the line low for 50 cycles, then high, then send 0x3C → `frame_error` pulses once, no byte for the bad frame, then 0x3C is received.
- Assert `reset` low midway through 0x7E → all outputs at reset values. After release, the next full frame 0x81 is received correctly.
- With `UART_RX_PARITY_EN`, send 0x07 with the parity bit = 0 → `parity_error` pulses and no byte. With the correct parity bit = 1 → `rx_data`=0x07.
